led_blink_sequencer: RTL and testbench

Shares one status LED between NUM_REQ requesters. Each requester asks for a burst of N blinks. The block arbitrates round-robin, then sequences ON/OFF/GAP phases using a prescaled tick. It sits between status-generating logic (error, activity, heartbeat sources) and the board LED pin, and replaces free-running single-purpose blink counters.

---
 rtl/led_seq_pkg.sv | 21 ++
 rtl/led_blink_sequencer_tick_prescaler.sv | 22 ++
 rtl/led_blink_sequencer.sv | 128 ++++++++++++
 tb/tb_led_blink_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared state encoding, count width and timer sizing for the LED blink sequencer.
package led_seq_pkg;

    localparam int COUNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_e;

    // Width needed to count 0 .. max(phase lengths)-1, never below one bit.
    function automatic int timer_w(input int on_t, input int off_t, input int gap_t);
        int m;
        m = (on_t > off_t) ? on_t : off_t;
        m = (m > gap_t) ? m : gap_t;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/led_blink_sequencer_tick_prescaler.sv
// tick_prescaler: free-running counter with synchronous clear; tick flags the all-ones count.
module tick_prescaler #(
    parameter int BITS = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    logic [BITS-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer: round-robin arbiter sharing one LED among requesters,
// each granted burst plays N ON/OFF blinks followed by a dark gap.
module led_blink_sequencer
    import led_seq_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int PRESCALE_BITS = 22,
    parameter  int ON_TICKS      = 3,
    parameter  int OFF_TICKS     = 3,
    parameter  int GAP_TICKS     = 8,
    localparam int GRANT_W       = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*COUNT_W-1:0] req_count,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       led,
    output logic                       busy,
    output logic                       done,
    output logic [GRANT_W-1:0]         grant_id
);

    localparam int TIMER_W = timer_w(ON_TICKS, OFF_TICKS, GAP_TICKS);

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   rem_q, rem_d;
    logic [TIMER_W-1:0]   timer_q, timer_d, phase_last;
    logic [GRANT_W-1:0]   last_grant_q, last_grant_d, grant_id_q, grant_id_d;
    logic [GRANT_W-1:0]   cand, sel;
    logic                 led_q, led_d, busy_q, busy_d, done_q, done_d;
    logic                 tick, xfer, phase_end;
    logic [COUNT_W-1:0]   cnt [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        assign cnt[i] = req_count[i*COUNT_W +: COUNT_W];
    end

    // Prescaler restarts on every transfer so the first phase is full length.
    tick_prescaler #(.BITS(PRESCALE_BITS)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .clr  (xfer),
        .tick (tick)
    );

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        req_ready = '0;
        sel       = '0;
        cand      = '0;
        xfer      = 1'b0;
        if (state_q == IDLE) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = GRANT_W'((int'(last_grant_q) + k) % NUM_REQ);
                if (!xfer && req_valid[cand]) begin
                    xfer = 1'b1;
                    sel  = cand;
                end
            end
            if (xfer) req_ready[sel] = 1'b1;
        end
    end

    assign phase_last = (state_q == ON)  ? TIMER_W'(ON_TICKS - 1)  :
                        (state_q == OFF) ? TIMER_W'(OFF_TICKS - 1) :
                                           TIMER_W'(GAP_TICKS - 1);
    assign phase_end  = tick && (state_q != IDLE) && (timer_q == phase_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            timer_q      <= '0;
            last_grant_q <= GRANT_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            led_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            timer_q      <= timer_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        timer_d      = (tick && state_q != IDLE) ? (phase_end ? '0 : timer_q + 1'b1) : timer_q;
        case (state_q)
            IDLE: if (xfer) begin
                state_d      = (cnt[sel] != '0) ? ON : GAP;
                rem_d        = cnt[sel];
                timer_d      = '0;
                last_grant_d = sel;
                grant_id_d   = sel;
            end
            ON: if (phase_end) begin
                state_d = OFF;
                rem_d   = rem_q - 1'b1;
            end
            OFF:     if (phase_end) state_d = (rem_q != '0) ? ON : GAP;
            GAP:     if (phase_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with state_q.
    always_comb begin
        led_d  = (state_d == ON);
        busy_d = (state_d != IDLE);
        done_d = (state_q == GAP) && phase_end;
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// tb_led_blink_sequencer: directed scenarios for the LED blink sequencer with small timing parameters.
module tb_led_blink_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_count = '0;
    logic [3:0]  req_ready;
    logic        led, busy, done;
    logic [1:0]  grant_id;
    int          checks = 0;
    int          errors = 0;
    logic        led_seq [512];

    always #5 clk = ~clk;

    led_blink_sequencer #(
        .NUM_REQ(4), .PRESCALE_BITS(2), .ON_TICKS(2), .OFF_TICKS(1), .GAP_TICKS(3)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_count(req_count),
        .req_ready(req_ready), .led(led), .busy(busy), .done(done), .grant_id(grant_id)
    );

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Samples each negedge from the cycle after a transfer until busy drops.
    task automatic measure(output int nbusy, output int nrise, output int nhigh,
                           output int nbad, output logic dn, output logic to);
        logic prev;
        prev = 1'b0; nbusy = 0; nrise = 0; nhigh = 0; nbad = 0; dn = 1'b0; to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!$onehot0(req_ready)) nbad++;
            if (!busy) begin
                dn = done;
                to = 1'b0;
                break;
            end
            if (req_ready != '0 || done) nbad++;
            led_seq[nbusy] = led;
            if (led && !prev) nrise++;
            if (led) nhigh++;
            prev = led;
            nbusy++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL rst_led got %0b exp 0", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", done); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant got %0d exp 0", grant_id); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_single_burst;
        int nb, nr, nh, nbad, pat_err;
        logic dn, to, exp_led;
        do_reset();
        req_count = 16'h0003;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t1_ready got %b exp 0001", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        measure(nb, nr, nh, nbad, dn, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL t1_timeout got %0b exp 0", to); end
        checks++; if (nb != 48) begin errors++; $display("FAIL t1_busy got %0d exp 48", nb); end
        checks++; if (nr != 3) begin errors++; $display("FAIL t1_rises got %0d exp 3", nr); end
        checks++; if (nh != 24) begin errors++; $display("FAIL t1_high got %0d exp 24", nh); end
        pat_err = 0;
        for (int c = 0; c < 48; c++) begin
            exp_led = (c < 36) && (c % 12 < 8);
            if (c < nb && led_seq[c] !== exp_led) pat_err++;
        end
        checks++; if (pat_err != 0) begin errors++; $display("FAIL t1_pattern got %0d bad cycles exp 0", pat_err); end
        checks++; if (nbad != 0) begin errors++; $display("FAIL t1_ready_busy got %0d exp 0", nbad); end
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL t1_done got %0b exp 1", dn); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL t1_grant got %0d exp 0", grant_id); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse got %0b exp 0", done); end
    endtask

    task automatic test_back_to_back;
        int nb, nr, nh, nbad;
        logic dn, to;
        logic [3:0] exp_rdy;
        do_reset();
        req_count = 16'h1111;
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t2_ready0 got %b exp 0001", req_ready); end
        for (int b = 0; b < 3; b++) begin
            @(posedge clk);
            measure(nb, nr, nh, nbad, dn, to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL t2_timeout[%0d] got %0b exp 0", b, to); end
            checks++; if (nb != 24) begin errors++; $display("FAIL t2_busy[%0d] got %0d exp 24", b, nb); end
            checks++; if (nr != 1) begin errors++; $display("FAIL t2_rises[%0d] got %0d exp 1", b, nr); end
            checks++; if (nbad != 0) begin errors++; $display("FAIL t2_onehot[%0d] got %0d exp 0", b, nbad); end
            checks++; if (dn !== 1'b1) begin errors++; $display("FAIL t2_done[%0d] got %0b exp 1", b, dn); end
            checks++; if (grant_id !== 2'(b)) begin errors++; $display("FAIL t2_grant[%0d] got %0d exp %0d", b, grant_id, b); end
            exp_rdy = 4'b0001 << (b + 1);
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL t2_next_ready[%0d] got %b exp %b", b, req_ready, exp_rdy); end
        end
        req_valid = '0;
    endtask

    task automatic test_zero_count;
        int nb, nr, nh, nbad;
        logic dn, to;
        do_reset();
        req_count = 16'h0000;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL t3_ready got %b exp 0100", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        measure(nb, nr, nh, nbad, dn, to);
        checks++; if (nb != 12 || to) begin errors++; $display("FAIL t3_busy got %0d exp 12", nb); end
        checks++; if (nh != 0) begin errors++; $display("FAIL t3_high got %0d exp 0", nh); end
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL t3_done got %0b exp 1", dn); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL t3_grant got %0d exp 2", grant_id); end
    endtask

    task automatic test_reset_mid_burst;
        int nb, nr, nh, nbad;
        logic dn, to;
        do_reset();
        req_count = 16'h2050;
        req_valid = 4'b0010;
        @(posedge clk); #1 req_valid = '0;
        repeat (3) @(negedge clk);
        checks++; if (led !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL t4_on got led %0b busy %0b exp 1 1", led, busy); end
        rst = 1'b1;
        req_valid = 4'b1000;
        @(negedge clk);
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL t4_led got %0b exp 0", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_busy got %0b exp 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL t4_grant_rst got %0d exp 0", grant_id); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL t4_ready got %b exp 1000", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        measure(nb, nr, nh, nbad, dn, to);
        checks++; if (nb != 36 || to) begin errors++; $display("FAIL t4_busy_len got %0d exp 36", nb); end
        checks++; if (nr != 2) begin errors++; $display("FAIL t4_rises got %0d exp 2", nr); end
        checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL t4_grant got %0d exp 3", grant_id); end
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL t4_done got %0b exp 1", dn); end
    endtask

    task automatic test_drop_while_busy;
        int nb, nr, nh, nbad, acks, extra;
        logic dn, to;
        do_reset();
        req_count = 16'h0001;
        req_valid = 4'b0001;
        @(posedge clk); #1 req_valid = '0;
        repeat (3) @(negedge clk);
        req_valid = 4'b0010;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (req_ready != '0) acks++;
        end
        req_valid = '0;
        checks++; if (acks != 0) begin errors++; $display("FAIL t5_acks got %0d exp 0", acks); end
        measure(nb, nr, nh, nbad, dn, to);
        checks++; if (nb != 16 || to) begin errors++; $display("FAIL t5_busy got %0d exp 16", nb); end
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL t5_done got %0b exp 1", dn); end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL t5_extra got %0d exp 0", extra); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL t5_grant got %0d exp 0", grant_id); end
    endtask

    task automatic test_max_count;
        int nb, nr, nh, nbad;
        logic dn, to;
        do_reset();
        req_count = 16'h000F;
        req_valid = 4'b0001;
        @(posedge clk); #1 req_valid = '0;
        measure(nb, nr, nh, nbad, dn, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL t6_timeout got %0b exp 0", to); end
        checks++; if (nb != 192) begin errors++; $display("FAIL t6_busy got %0d exp 192", nb); end
        checks++; if (nr != 15) begin errors++; $display("FAIL t6_rises got %0d exp 15", nr); end
        checks++; if (nh != 120) begin errors++; $display("FAIL t6_high got %0d exp 120", nh); end
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL t6_done got %0b exp 1", dn); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_zero_count();
        test_reset_mid_burst();
        test_drop_while_busy();
        test_max_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
